// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: instruction layout, opcode classes and the
// dispatch FSM state encoding.
package cpu_pkg;

  localparam int unsigned OPC_W   = 4;
  localparam int unsigned P1_W    = 6;
  localparam int unsigned P2_W    = 6;
  localparam int unsigned INSTR_W = OPC_W + P1_W + P2_W;

  localparam logic [OPC_W-1:0] OP_NOP    = 4'b0000;
  localparam logic [OPC_W-1:0] OP_HALT   = 4'b0001;
  localparam logic [OPC_W-1:0] ALU_MASK  = 4'b1000;
  localparam logic [OPC_W-1:0] ALU_VAL   = 4'b1000;
  localparam logic [OPC_W-1:0] LDST_MASK = 4'b1110;
  localparam logic [OPC_W-1:0] LDST_VAL  = 4'b0010;
  localparam logic [OPC_W-1:0] BR_MASK   = 4'b1100;
  localparam logic [OPC_W-1:0] BR_VAL    = 4'b0100;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [P1_W-1:0]  param1;
    logic [P2_W-1:0]  param2;
  } instr_t;

  typedef struct packed {
    logic nop;
    logic halt;
    logic ldst;
    logic br;
    logic alu;
  } op_class_t;

  typedef struct packed {
    logic mem_rd;
    logic act_alu;
    logic act_ldst;
    logic act_br;
    logic pc_inc;
    logic busy;
    logic halted;
    logic err_timeout;
  } disp_out_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ACTIVATE,
    ST_WAIT_DONE,
    ST_HALTED,
    ST_ERROR
  } disp_state_e;

  function automatic logic op_match(input logic [OPC_W-1:0] op,
                                    input logic [OPC_W-1:0] mask,
                                    input logic [OPC_W-1:0] val);
    return (op & mask) == val;
  endfunction

endpackage

// File: rtl/instr_dispatch_fsm_if.sv
// Fetch bus, run control and execute-unit activate/done handshake of the dispatcher.
interface instr_dispatch_fsm_if;
  import cpu_pkg::*;

  logic               run;
  logic               mem_rd;
  logic               mem_valid;
  logic [INSTR_W-1:0] instr_in;
  logic [OPC_W-1:0]   opcode;
  logic [P1_W-1:0]    param1;
  logic [P2_W-1:0]    param2;
  logic               act_alu;
  logic               act_ldst;
  logic               act_br;
  logic               done_alu;
  logic               done_ldst;
  logic               done_br;
  logic               pc_inc;
  logic               busy;
  logic               halted;
  logic               err_timeout;

  modport master (
    input  run, mem_valid, instr_in, done_alu, done_ldst, done_br,
    output mem_rd, opcode, param1, param2, act_alu, act_ldst, act_br,
           pc_inc, busy, halted, err_timeout
  );

  modport slave (
    output run, mem_valid, instr_in, done_alu, done_ldst, done_br,
    input  mem_rd, opcode, param1, param2, act_alu, act_ldst, act_br,
           pc_inc, busy, halted, err_timeout
  );

endinterface

// File: rtl/opcode_class_dec.sv
// Opcode to one-hot class decode; the five classes are disjoint and cover all opcodes.
module opcode_class_dec
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output op_class_t        cls_o
);

  assign cls_o.nop  = (opcode_i == OP_NOP);
  assign cls_o.halt = (opcode_i == OP_HALT);
  assign cls_o.alu  = op_match(opcode_i, ALU_MASK, ALU_VAL);
  assign cls_o.ldst = op_match(opcode_i, LDST_MASK, LDST_VAL);
  assign cls_o.br   = op_match(opcode_i, BR_MASK, BR_VAL);

endmodule

// File: rtl/instr_dispatch_fsm.sv
// Instruction dispatcher: fetch, latch, decode, activate one execute unit and
// wait for its done with stale-done blanking and a hung-unit timeout.
module instr_dispatch_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned BLANK_CYC   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_dispatch_fsm_if.master bus
);

  localparam int unsigned     CNT_W     = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  disp_state_e      state_q, state_d;
  instr_t           ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  disp_out_t        out_q, out_d;
  op_class_t        cls;
  logic             done_sel;

  // Decoding ir_d lets pc_inc be registered into the DECODE cycle itself.
  opcode_class_dec u_dec (
    .opcode_i (ir_d.opcode),
    .cls_o    (cls)
  );

  assign done_sel = (cls.alu  & bus.done_alu)
                  | (cls.ldst & bus.done_ldst)
                  | (cls.br   & bus.done_br);

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    out_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.mem_valid) begin
          ir_d    = instr_t'(bus.instr_in);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cls.nop) begin
          state_d = bus.run ? ST_FETCH : ST_IDLE;
        end else if (cls.halt) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_ACTIVATE;
          cnt_d   = '0;
        end
      end
      ST_ACTIVATE: begin
        state_d = ST_WAIT_DONE;
        cnt_d   = CNT_W'(1);
      end
      ST_WAIT_DONE: begin
        // cnt_q is the number of cycles since the activate pulse.
        if (cnt_q > CNT_BLANK && done_sel) begin
          state_d = bus.run ? ST_FETCH : ST_IDLE;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d = ST_ERROR;
        end
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end
      ST_HALTED: state_d = ST_HALTED;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_IDLE;
    endcase

    out_d.mem_rd      = (state_d == ST_FETCH);
    out_d.busy        = !(state_d inside {ST_IDLE, ST_HALTED, ST_ERROR});
    out_d.halted      = (state_d == ST_HALTED);
    out_d.err_timeout = (state_d == ST_ERROR);
    out_d.pc_inc      = (state_d == ST_DECODE) && cls.nop;
    if (state_d == ST_ACTIVATE) begin
      out_d.act_alu  = cls.alu;
      out_d.act_ldst = cls.ldst;
      out_d.act_br   = cls.br;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign bus.mem_rd      = out_q.mem_rd;
  assign bus.act_alu     = out_q.act_alu;
  assign bus.act_ldst    = out_q.act_ldst;
  assign bus.act_br      = out_q.act_br;
  assign bus.pc_inc      = out_q.pc_inc;
  assign bus.busy        = out_q.busy;
  assign bus.halted      = out_q.halted;
  assign bus.err_timeout = out_q.err_timeout;
  assign bus.opcode      = ir_q.opcode;
  assign bus.param1      = ir_q.param1;
  assign bus.param2      = ir_q.param2;

endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// Self-checking bench for instr_dispatch_fsm: directed handshake cases plus a
// random instruction sweep against a transaction-level timing model.
module tb_instr_dispatch_fsm;
  import cpu_pkg::*;

  localparam int unsigned TO = 64;
  localparam int unsigned BL = 2;

  // Status vector: {act_alu, act_ldst, act_br, pc_inc, mem_rd, busy, halted, err}
  localparam logic [7:0] S_IDLE  = 8'h00;
  localparam logic [7:0] S_FETCH = 8'h0C;
  localparam logic [7:0] S_BUSY  = 8'h04;
  localparam logic [7:0] S_PC    = 8'h14;
  localparam logic [7:0] S_HALT  = 8'h02;
  localparam logic [7:0] S_ERR   = 8'h01;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  bit   held [3];

  always #5 clk = ~clk;

  instr_dispatch_fsm_if bus ();

  instr_dispatch_fsm #(.TIMEOUT_CYC(TO), .BLANK_CYC(BL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] stat();
    return {bus.act_alu, bus.act_ldst, bus.act_br, bus.pc_inc,
            bus.mem_rd, bus.busy, bus.halted, bus.err_timeout};
  endfunction

  // 0 alu, 1 ldst, 2 br, 3 nop, 4 halt
  function automatic int exp_unit(input logic [3:0] op);
    if (op[3]) return 0;
    if (op[2]) return 2;
    if (op[1]) return 1;
    if (op[0]) return 4;
    return 3;
  endfunction

  function automatic logic [7:0] act_vec(input int u);
    case (u)
      0:       return 8'h84;
      1:       return 8'h44;
      default: return 8'h24;
    endcase
  endfunction

  // Selected unit gets the modelled level; the others get noise that must be ignored.
  task automatic drive_done(input int u, input bit lvl);
    logic [2:0] r;
    r = 3'($urandom);
    case (u)
      0: r[2] = lvl;
      1: r[1] = lvl;
      2: r[0] = lvl;
      default: ;
    endcase
    bus.done_alu  = r[2];
    bus.done_ldst = r[1];
    bus.done_br   = r[0];
    if (u < 3) held[u] = lvl;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_outputs", 32'(stat()), 32'(S_IDLE));
    check("rst_ir", 32'({bus.opcode, bus.param1, bus.param2}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  // rise: WAIT cycle (counted from the activate pulse) where the selected done
  // goes high; 0 means never. The previous done level persists through blanking.
  task automatic do_instr(input logic [15:0] ins, input int rise,
                          input bit drop_run, input bit rst_at_act);
    int u;
    int acc;
    int k;
    bit stale;
    bit lvl [$];
    u = exp_unit(ins[15:12]);
    k = 0;
    while (bus.mem_rd !== 1'b1 && k < 4) begin
      step();
      k++;
    end
    check("fetch_req", 32'(bus.mem_rd), 32'(1));
    bus.mem_valid = 1'b1;
    bus.instr_in  = ins;
    step();
    bus.mem_valid = 1'b0;
    bus.instr_in  = 16'($urandom);
    check("ir_latch", 32'({bus.opcode, bus.param1, bus.param2}), 32'(ins));
    check("decode", 32'(stat()), 32'((u == 3) ? S_PC : S_BUSY));
    step();
    if (u == 3) begin
      check("nop_next", 32'(stat()), 32'(bus.run ? S_FETCH : S_IDLE));
      return;
    end
    if (u == 4) begin
      bus.run = 1'b1;
      repeat (3) begin
        check("halted", 32'(stat()), 32'(S_HALT));
        step();
      end
      return;
    end
    check("activate", 32'(stat()), 32'(act_vec(u)));
    if (rst_at_act) begin
      do_reset();
      return;
    end
    stale = held[u];
    lvl.push_back(1'b0);
    for (int n = 1; n <= int'(TO); n++)
      lvl.push_back((n <= int'(BL)) ? stale : (rise != 0 && n >= rise));
    acc = 0;
    for (int n = int'(BL) + 1; n < int'(TO); n++)
      if (acc == 0 && lvl[n]) acc = n;
    for (int n = 1; n < int'(TO); n++) begin
      step();
      check("wait_done", 32'(stat()), 32'(S_BUSY));
      if (drop_run && n == 1) bus.run = 1'b0;
      drive_done(u, lvl[n]);
      if (n == acc) begin
        step();
        check("done_exit", 32'(stat()), 32'(bus.run ? S_FETCH : S_IDLE));
        return;
      end
    end
    step();
    check("timeout", 32'(stat()), 32'(S_ERR));
    check("err_ir_hold", 32'({bus.opcode, bus.param1, bus.param2}), 32'(ins));
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rise;
    int u;
    logic [15:0] ins;
    rst           = 1'b1;
    bus.run       = 1'b0;
    bus.mem_valid = 1'b0;
    bus.instr_in  = '0;
    bus.done_alu  = 1'b0;
    bus.done_ldst = 1'b0;
    bus.done_br   = 1'b0;
    for (int i = 0; i < 3; i++) held[i] = 1'b0;
    repeat (2) step();
    check("reset_state", 32'(stat()), 32'(S_IDLE));
    check("reset_ir", 32'({bus.opcode, bus.param1, bus.param2}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    step();
    check("idle_no_run", 32'(stat()), 32'(S_IDLE));
    bus.run = 1'b1;

    do_instr(16'h80C3, 5, 1'b0, 1'b0);
    do_instr(16'h9ABC, 6, 1'b0, 1'b0);
    do_instr(16'h0000, 0, 1'b0, 1'b0);
    do_instr(16'h4000, int'(TO) - 1, 1'b0, 1'b0);
    do_instr(16'h4000, 0, 1'b0, 1'b0);
    do_reset();
    do_instr(16'h2000, 4, 1'b1, 1'b0);
    step();
    check("parked_idle", 32'(stat()), 32'(S_IDLE));
    bus.run = 1'b1;
    do_instr(16'h2555, 5, 1'b0, 1'b1);
    do_instr(16'h1000, 0, 1'b0, 1'b0);
    do_reset();

    for (int i = 0; i < 40; i++) begin
      ins  = 16'($urandom);
      u    = exp_unit(ins[15:12]);
      rise = ($urandom_range(19, 0) == 0) ? 0 : int'($urandom_range(BL + 12, 1));
      do_instr(ins, rise, ($urandom_range(7, 0) == 0), 1'b0);
      if (u == 4 || (u < 3 && rise == 0)) do_reset();
      bus.run = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
